pipe_rca4: RTL and testbench

PIPE_RCA4 -- requirements
Module: pipe_rca4

---
 rtl/pipe_rca4.sv | 79 +++++++
 tb/tb_pipe_rca4.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pipe_rca4.sv
// Four-stage pipelined 4-bit ripple-carry adder: one full adder per stage, carry registered between stages.
// Inputs sampled at edge N appear on Sum/Cout after edge N+3; no handshake, a new operand set every cycle.
module pipe_rca4 (
    output logic       Cout,
    output logic [3:0] Sum,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    input  logic       Clk,
    input  logic       Rst
);

    // Returns {carry_out, sum} of one bit position.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {1'b0, a} + {1'b0, b} + {1'b0, c};
    endfunction

    // Stage 1: bit 0 done, bits 3:1 of the operands ride along.
    logic       s1_sum;
    logic       s1_c;
    logic [3:1] s1_a;
    logic [3:1] s1_b;

    // Stage 2: bits 1:0 done.
    logic [1:0] s2_sum;
    logic       s2_c;
    logic [3:2] s2_a;
    logic [3:2] s2_b;

    // Stage 3: bits 2:0 done.
    logic [2:0] s3_sum;
    logic       s3_c;
    logic       s3_a;
    logic       s3_b;

    // Stage 4: complete result, drives the outputs directly.
    logic [3:0] s4_sum;
    logic       s4_c;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            s1_sum <= 1'b0;
            s1_c   <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s2_sum <= '0;
            s2_c   <= 1'b0;
            s2_a   <= '0;
            s2_b   <= '0;
            s3_sum <= '0;
            s3_c   <= 1'b0;
            s3_a   <= 1'b0;
            s3_b   <= 1'b0;
            s4_sum <= '0;
            s4_c   <= 1'b0;
        end else begin
            {s1_c, s1_sum} <= full_add(A[0], B[0], Cin);
            s1_a           <= A[3:1];
            s1_b           <= B[3:1];

            {s2_c, s2_sum[1]} <= full_add(s1_a[1], s1_b[1], s1_c);
            s2_sum[0]         <= s1_sum;
            s2_a              <= s1_a[3:2];
            s2_b              <= s1_b[3:2];

            {s3_c, s3_sum[2]} <= full_add(s2_a[2], s2_b[2], s2_c);
            s3_sum[1:0]       <= s2_sum;
            s3_a              <= s2_a[3];
            s3_b              <= s2_b[3];

            {s4_c, s4_sum[3]} <= full_add(s3_a, s3_b, s3_c);
            s4_sum[2:0]       <= s3_sum;
        end
    end

    assign Sum  = s4_sum;
    assign Cout = s4_c;

endmodule

// File: tb/tb_pipe_rca4.sv
// Bench for pipe_rca4: directed cases, streaming, async reset and a random stream vs a delayed-sum model.
module tb_pipe_rca4;

    logic       Cout;
    logic [3:0] Sum;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic       Clk;
    logic       Rst;

    int checks;
    int failures;

    // Expected results in sampling order; the head is what the outputs should show now.
    logic [4:0] model_q[$];

    pipe_rca4 dut (
        .Cout(Cout),
        .Sum (Sum),
        .A   (A),
        .B   (B),
        .Cin (Cin),
        .Clk (Clk),
        .Rst (Rst)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [4:0] expected);
        checks++;
        assert ({Cout, Sum} === expected)
        else begin
            failures++;
            $error("FAIL %s: observed %b expected %b", tag, {Cout, Sum}, expected);
        end
    endtask

    task automatic model_clear();
        model_q = '{5'd0, 5'd0, 5'd0, 5'd0};
    endtask

    // Drive one operand set, take one edge, check against the model 1ns later.
    task automatic cycle(input logic [3:0] a, input logic [3:0] b, input logic [1:0] c, input string tag);
        logic [4:0] s;
        A   = a;
        B   = b;
        Cin = c[0];
        s = 5'(a) + 5'(b) + 5'(c % 2);
        @(posedge Clk);
        model_q.push_back(s);
        void'(model_q.pop_front());
        #1;
        check(tag, model_q[0]);
    endtask

    task automatic single(input logic [3:0] a, input logic [3:0] b, input logic [1:0] c,
                          input logic [4:0] expected, input string tag);
        cycle(a, b, c, tag);
        repeat (3) cycle(4'd0, 4'd0, 2'd0, tag);
        check({tag, "_lit"}, expected);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        A   = '0;
        B   = '0;
        Cin = 1'b0;
        Rst = 1'b1;
        model_clear();
        #1;
        check("reset_state", 5'b00000);
        @(posedge Clk);
        #1;
        check("reset_hold", 5'b00000);
        #3 Rst = 1'b0;

        repeat (4) cycle(4'd0, 4'd0, 2'd0, "zero_in");

        single(4'd7,  4'd5,  2'd0, 5'b01100, "7_5_0");
        single(4'd7,  4'd5,  2'd1, 5'b01101, "7_5_1");
        single(4'd10, 4'd6,  2'd0, 5'b10000, "10_6_0");
        single(4'd4,  4'd10, 2'd1, 5'b01111, "4_10_1");
        single(4'd0,  4'd6,  2'd1, 5'b00111, "0_6_1");
        single(4'd0,  4'd0,  2'd1, 5'b00001, "0_0_1");
        single(4'd3,  4'd0,  2'd0, 5'b00011, "3_0_0");
        single(4'd2,  4'd2,  2'd2, 5'b00100, "cin_wide");
        single(4'd15, 4'd15, 2'd1, 5'b11111, "15_15_1");
        single(4'd15, 4'd0,  2'd1, 5'b10000, "15_0_1");

        // Back-to-back stream.
        cycle(4'd7,  4'd5,  2'd0, "stream");
        cycle(4'd10, 4'd6,  2'd0, "stream");
        cycle(4'd15, 4'd15, 2'd1, "stream");
        cycle(4'd0,  4'd0,  2'd0, "stream");
        check("stream_0", 5'b01100);
        cycle(4'd0, 4'd0, 2'd0, "stream");
        check("stream_1", 5'b10000);
        cycle(4'd0, 4'd0, 2'd0, "stream");
        check("stream_2", 5'b11111);
        cycle(4'd0, 4'd0, 2'd0, "stream");
        check("stream_3", 5'b00000);

        // Async reset while the output shows a non-zero result.
        cycle(4'd9, 4'd9, 2'd1, "pre_rst");
        repeat (3) cycle(4'd9, 4'd9, 2'd1, "pre_rst");
        check("pre_rst_lit", 5'b10011);
        #2 Rst = 1'b1;
        #1;
        check("rst_immediate", 5'b00000);
        #3 Rst = 1'b0;
        model_clear();
        repeat (4) cycle(4'd0, 4'd0, 2'd0, "post_rst");

        // Reset mid-flight: 15+15+1 sampled, reset pulsed one cycle later between edges.
        cycle(4'd15, 4'd15, 2'd1, "flight");
        cycle(4'd0,  4'd0,  2'd0, "flight");
        #3 Rst = 1'b1;
        #1;
        check("flight_rst", 5'b00000);
        @(posedge Clk);
        #1;
        check("flight_rst_hold", 5'b00000);
        #3 Rst = 1'b0;
        model_clear();
        for (int i = 0; i < 6; i++) begin
            cycle(4'd0, 4'd0, 2'd0, "flight_after");
            check("flight_no_stale", 5'b00000);
        end

        // First edge after deassertion samples normally.
        single(4'd6, 4'd3, 2'd1, 5'b01010, "post_rst_first");

        // Random stream.
        for (int i = 0; i < 1200; i++) begin
            cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)), "random");
        end
        repeat (3) cycle(4'd0, 4'd0, 2'd0, "random_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
